axi3_master_wr_ctrl: RTL and testbench
======================================

Name: axi3_master_wr_ctrl

Overview:
Parametrised AXI3 master write-path controller covering the write address, write data and write response channels under one FSM.
- Accepts a burst command and a beat stream from local master logic.
- Drives AW then W with WLAST generation, then collects B.
- Checks BID, flags error responses, and optionally times out a missing response.
- Sits between the master behaviour model and the interconnect/slave; supersedes the fixed-width write-address-only FSM.

Parameters:
DATAWIDTH, 32, W data bus width in bits (multiple of 8, 32..1024)
ADDRWIDTH, 32, address width
IDWIDTH, 4, AWid/Wid/Bid width
SIZE, 3, AWsize width; AWburst is SIZE-1 bits
TIMEOUT, 256, cycles to wait for BVALID after WLAST handshake; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  controller can accept a command
cmd_addr  in  ADDRWIDTH  start address
cmd_id  in  IDWIDTH  transaction ID
cmd_len  in  4  beats-1 (AXI3, 0..15)
cmd_size  in  SIZE  bytes/beat = 2^size; must be <= DATAWIDTH/8
cmd_burst  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP
wd_valid  in  1  local write beat valid
wd_ready  out  1  local write beat accepted
wd_data  in  DATAWIDTH  beat data
wd_strb  in  DATAWIDTH/8  beat byte strobes
AWid/AWaddr/AWlen/AWsize/AWburst  out  per params  AW payload
AWvalid  out  1; AWready  in  1
Wid  out  IDWIDTH; WData  out  DATAWIDTH; WStrb  out  DATAWIDTH/8; WLast  out  1
Wvalid  out  1; Wready  in  1
Bid  in  IDWIDTH; Bresp  in  2; Bvalid  in  1; Bready  out  1
done  out  1  one-cycle pulse at burst completion
resp  out  2  captured Bresp, valid with done
err  out  1  sticky: resp!=OKAY, Bid mismatch, or timeout; cleared on next command accept

Behaviour:
- Reset (async, rst=1): state IDLE.
  - Outputs: cmd_ready=1; all valid/ready/last outputs 0; payload outputs 0; done=0, resp=0, err=0; counters 0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch command into regs, clear err, beat_cnt=0.
  - Next state ADDR; AWvalid=1 in the following cycle.
- ADDR:
  - AWvalid held with stable payload until AWready.
  - On AWvalid&AWready: AWvalid<=0, next state DATA.
  - W never leads AW.
- DATA:
  - Combinational pass-through: Wvalid=wd_valid, wd_ready=Wready; WData/WStrb from wd_*; Wid=latched id.
  - Zero added latency.
  - WLast=1 when beat_cnt==latched len.
  - Each W handshake increments beat_cnt.
  - The handshake with WLast=1 moves to RESP and arms the timeout counter.
  - Strobes pass unmodified; lane alignment is the source's responsibility.
- RESP:
  - Bready=1.
  - On Bvalid:
    - Capture Bresp into resp.
    - err|= (Bresp!=0) | (Bid!=latched id).
    - done pulses 1 cycle.
    - Next state IDLE.
  - Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 without Bvalid, set err=1, resp=2'b10 (SLVERR), pulse done, go IDLE.
  - Bvalid arriving in the same cycle as expiry wins: its Bresp is used; timeout is not flagged.
- Back-to-back: done cycle is in RESP→IDLE; a new command is accepted on the first IDLE cycle (minimum 1 idle cycle between bursts).
- Command checks:
  - cmd_size > log2(DATAWIDTH/8), or WRAP with len not in {1,3,7,15}: command still accepted.
  - Burst is issued as given; err set at accept.
  - The AXI slave is expected to return SLVERR for such commands.
- Unexpected inputs:
  - AWready outside ADDR, Wready outside DATA, Bvalid outside RESP: ignored.
  - wd_ready=0 outside DATA.
- Reset mid-burst: immediate return to IDLE, all valids dropped. No partial-burst completion; no done pulse.

Decomposition:
- Shared package axi3_pkg:
  - burst_e (FIXED/INCR/WRAP)
  - resp_e (OKAY/EXOKAY/SLVERR/DECERR)
  - wr_state_e
  - AXI3 max-len constant 16
  - localparam helper STRBWIDTH=DATAWIDTH/8
- One sub-module: axi3_wr_timeout, a loadable down-counter with arm/clear/expire. Keep the FSM, beat counter and latches in the top.

Test Plan:
- Single beat INCR: addr=0x100, id=3, len=0, size=2; AWready/Wready/Bvalid immediate, Bresp=0, Bid=3 → AWlen=0, one W with WLast=1, done after Bvalid, resp=0, err=0.
- INCR len=7 with Wready toggling 1,0,1,… and wd_valid gaps → exactly 8 W handshakes, WLast only on the 8th, data order preserved, AWvalid stable until AWready (delayed 5 cycles).
- Response error: len=3, Bresp=2'b10 → resp=2, err=1. Next command accepted clears err to 0.
- Bid mismatch: cmd_id=5, Bid=6, Bresp=0 → err=1, resp=0, done pulses.
- Timeout with TIMEOUT=16: Bvalid never asserted → done and err at cycle 16 after WLast handshake, resp=2, state IDLE. Repeat with Bvalid at cycle 15 → resp=Bresp, no timeout.
- rst asserted mid-DATA after beat 2 of len=7 → all outputs at reset values in the same cycle; no done. Post-reset command runs normally.

Source files
------------

// File: rtl/axi3_pkg.sv
// Shared AXI3 write-path types and helpers.
package axi3_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_e;

    localparam int AXI3_MAX_LEN = 16;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi3_wr_timeout.sv
// Loadable down-counter guarding the write-response wait.
module axi3_wr_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst, load, clear, en};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;
            logic          armed;

            // Loaded at the last W beat, so expiry lands on the TIMEOUT-th wait cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt   <= '0;
                    armed <= 1'b0;
                end else if (clear) begin
                    armed <= 1'b0;
                end else if (load) begin
                    cnt   <= LOAD_VAL;
                    armed <= 1'b1;
                end else if (armed && en) begin
                    if (cnt == '0) armed <= 1'b0;
                    else           cnt   <= cnt - 1'b1;
                end
            end

            assign expire = armed & en & (cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/axi3_master_wr_ctrl.sv
// AXI3 master write controller: one burst at a time through AW, W and B.
module axi3_master_wr_ctrl
    import axi3_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int IDWIDTH   = 4,
    parameter int SIZE      = 3,
    parameter int TIMEOUT   = 256,
    localparam int STRBWIDTH = strb_width(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [IDWIDTH-1:0]   cmd_id,
    input  logic [3:0]           cmd_len,
    input  logic [SIZE-1:0]      cmd_size,
    input  logic [SIZE-2:0]      cmd_burst,
    input  logic                 wd_valid,
    output logic                 wd_ready,
    input  logic [DATAWIDTH-1:0] wd_data,
    input  logic [STRBWIDTH-1:0] wd_strb,
    output logic [IDWIDTH-1:0]   AWid,
    output logic [ADDRWIDTH-1:0] AWaddr,
    output logic [3:0]           AWlen,
    output logic [SIZE-1:0]      AWsize,
    output logic [SIZE-2:0]      AWburst,
    output logic                 AWvalid,
    input  logic                 AWready,
    output logic [IDWIDTH-1:0]   Wid,
    output logic [DATAWIDTH-1:0] WData,
    output logic [STRBWIDTH-1:0] WStrb,
    output logic                 WLast,
    output logic                 Wvalid,
    input  logic                 Wready,
    input  logic [IDWIDTH-1:0]   Bid,
    input  logic [1:0]           Bresp,
    input  logic                 Bvalid,
    output logic                 Bready,
    output logic                 done,
    output logic [1:0]           resp,
    output logic                 err
);

    localparam logic [1:0] S_IDLE = WR_IDLE;
    localparam logic [1:0] S_ADDR = WR_ADDR;
    localparam logic [1:0] S_DATA = WR_DATA;
    localparam logic [1:0] S_RESP = WR_RESP;

    localparam int            MAX_SIZE = $clog2(STRBWIDTH);
    localparam logic [SIZE-2:0] B_WRAP = (SIZE-1)'(BURST_WRAP);

    logic [1:0]           state;
    logic [ADDRWIDTH-1:0] lat_addr;
    logic [IDWIDTH-1:0]   lat_id;
    logic [3:0]           lat_len;
    logic [SIZE-1:0]      lat_size;
    logic [SIZE-2:0]      lat_burst;
    logic [3:0]           beat_cnt;

    logic in_data, w_fire, last_fire, b_fire, tmo_expire, bad_cmd;

    assign cmd_ready = (state == S_IDLE);
    assign AWvalid   = (state == S_ADDR);
    assign in_data   = (state == S_DATA);
    assign Bready    = (state == S_RESP);

    assign AWid    = lat_id;
    assign AWaddr  = lat_addr;
    assign AWlen   = lat_len;
    assign AWsize  = lat_size;
    assign AWburst = lat_burst;

    // W is a straight pass-through of the local beat stream, gated to the data phase.
    assign Wvalid   = in_data & wd_valid;
    assign wd_ready = in_data & Wready;
    assign WData    = in_data ? wd_data : '0;
    assign WStrb    = in_data ? wd_strb : '0;
    assign WLast    = in_data & (beat_cnt == lat_len);
    assign Wid      = lat_id;

    assign w_fire    = Wvalid & Wready;
    assign last_fire = w_fire & WLast;
    assign b_fire    = Bready & Bvalid;

    // Illegal commands still go out on the bus; the slave answers with SLVERR.
    assign bad_cmd = (32'(cmd_size) > 32'(MAX_SIZE)) ||
                     ((cmd_burst == B_WRAP) && !wrap_len_ok(cmd_len));

    axi3_wr_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .load   (last_fire),
        .clear  (b_fire),
        .en     (Bready),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lat_addr  <= '0;
            lat_id    <= '0;
            lat_len   <= '0;
            lat_size  <= '0;
            lat_burst <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
            resp      <= 2'b00;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        lat_addr  <= cmd_addr;
                        lat_id    <= cmd_id;
                        lat_len   <= cmd_len;
                        lat_size  <= cmd_size;
                        lat_burst <= cmd_burst;
                        beat_cnt  <= '0;
                        err       <= bad_cmd;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (AWready) state <= S_DATA;
                end
                S_DATA: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (WLast) state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // A response arriving on the expiry cycle takes priority.
                    if (Bvalid) begin
                        resp  <= Bresp;
                        err   <= err | (Bresp != 2'b00) | (Bid != lat_id);
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (tmo_expire) begin
                        resp  <= RESP_SLVERR;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_master_wr_ctrl.sv
// Directed bench for axi3_master_wr_ctrl with W-beat and response scoreboards.
module tb_axi3_master_wr_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int SZ = 3;
    localparam int TO = 16;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [IW-1:0] cmd_id = '0;
    logic [3:0]    cmd_len = '0;
    logic [SZ-1:0] cmd_size = '0;
    logic [SZ-2:0] cmd_burst = '0;
    logic          wd_valid = 1'b0;
    logic          wd_ready;
    logic [DW-1:0] wd_data = '0;
    logic [SW-1:0] wd_strb = '0;
    logic [IW-1:0] AWid;
    logic [AW-1:0] AWaddr;
    logic [3:0]    AWlen;
    logic [SZ-1:0] AWsize;
    logic [SZ-2:0] AWburst;
    logic          AWvalid;
    logic          AWready = 1'b0;
    logic [IW-1:0] Wid;
    logic [DW-1:0] WData;
    logic [SW-1:0] WStrb;
    logic          WLast;
    logic          Wvalid;
    logic          Wready = 1'b0;
    logic [IW-1:0] Bid = '0;
    logic [1:0]    Bresp = '0;
    logic          Bvalid = 1'b0;
    logic          Bready;
    logic          done;
    logic [1:0]    resp;
    logic          err;

    always #5 clk = ~clk;

    axi3_master_wr_ctrl #(
        .DATAWIDTH(DW), .ADDRWIDTH(AW), .IDWIDTH(IW), .SIZE(SZ), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .AWid(AWid), .AWaddr(AWaddr), .AWlen(AWlen), .AWsize(AWsize), .AWburst(AWburst),
        .AWvalid(AWvalid), .AWready(AWready),
        .Wid(Wid), .WData(WData), .WStrb(WStrb), .WLast(WLast), .Wvalid(Wvalid), .Wready(Wready),
        .Bid(Bid), .Bresp(Bresp), .Bvalid(Bvalid), .Bready(Bready),
        .done(done), .resp(resp), .err(err)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
        logic [IW-1:0] id;
    } wexp_t;

    typedef struct packed {
        logic [1:0] r;
        logic       e;
    } bexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    int    total = 0;
    int    bad = 0;
    int    done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every W handshake and every done pulse pops an expectation.
    always @(negedge clk) begin
        wexp_t we;
        bexp_t be;
        if (!rst) begin
            if (Wvalid && Wready) begin
                if (wq.size() == 0) chk("w_unexpected", 64'(wq.size()), 64'd1);
                else begin
                    we = wq.pop_front();
                    chk("w_data", 64'(WData), 64'(we.d));
                    chk("w_strb", 64'(WStrb), 64'(we.s));
                    chk("w_last", 64'(WLast), 64'(we.l));
                    chk("w_id",   64'(Wid),   64'(we.id));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
                if (bq.size() == 0) chk("done_unexpected", 64'(bq.size()), 64'd1);
                else begin
                    be = bq.pop_front();
                    chk("done_resp", 64'(resp), 64'(be.r));
                    chk("done_err",  64'(err),  64'(be.e));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({cmd_ready, AWvalid, Wvalid, wd_ready, WLast, Bready, done, err}),
            64'(8'b1000_0000));
        chk({tag, "_aw"}, 64'({AWaddr, AWid, AWlen, AWsize, AWburst, Wid}), 64'd0);
        chk({tag, "_w"},  64'({WData, WStrb}), 64'd0);
        chk({tag, "_resp"}, 64'(resp), 64'd0);
    endtask

    task automatic run_burst(
        input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [3:0] len,
        input logic [SZ-1:0] size, input logic [SZ-2:0] burst,
        input int aw_dly, input bit wr_tog, input bit gap,
        input int b_dly, input bit b_never, input logic [1:0] bresp, input logic [IW-1:0] bid,
        input int stop_after
    );
        logic [DW-1:0] data [16];
        logic [SW-1:0] strb [16];
        wexp_t we;
        bexp_t be;
        bit    bad_cmd, pushed, seen;
        int    i, cyc, nrdy;

        bad_cmd = (size > 3'd2) || (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
        for (int k = 0; k < 16; k++) begin
            data[k] = $urandom;
            strb[k] = SW'($urandom_range(1, (1 << SW) - 1));
        end

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_id = id; cmd_len = len;
        cmd_size = size; cmd_burst = burst;
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_id = '0; cmd_len = '0;
        if (stop_after < 0) begin
            be.r = b_never ? 2'b10 : bresp;
            be.e = bad_cmd | b_never | (bresp != 2'b00) | (bid != id);
            bq.push_back(be);
        end

        // Address phase: first beat and Wready already offered, stray Bvalid present.
        wd_valid = 1'b1; wd_data = data[0]; wd_strb = strb[0]; Wready = 1'b1;
        we.d = data[0]; we.s = strb[0]; we.l = (len == 4'd0); we.id = id;
        wq.push_back(we);
        Bvalid = 1'b1; Bresp = 2'b11; Bid = ~id;
        for (int c = 0; c <= aw_dly; c++) begin
            AWready = (c == aw_dly);
            @(negedge clk);
            chk("aw_valid", 64'(AWvalid), 64'd1);
            chk("aw_addr",  64'(AWaddr),  64'(addr));
            chk("w_lead",   64'({Wvalid, wd_ready, Bready}), 64'd0);
            if (c == 0) begin
                chk("aw_ctl", 64'({AWid, AWlen, AWsize, AWburst}), 64'({id, len, size, burst}));
                chk("err_at_accept", 64'(err), 64'(bad_cmd));
            end
            @(posedge clk); #1;
        end
        AWready = 1'b0; Bvalid = 1'b0; Bresp = 2'b00; Bid = '0;

        i = 0; cyc = 0; pushed = 1'b1;
        while (i <= int'(len) && cyc < 100) begin
            wd_valid = !(gap && (cyc % 3 == 1));
            Wready   = wr_tog ? (cyc % 2 == 0) : 1'b1;
            wd_data  = data[i];
            wd_strb  = strb[i];
            if (wd_valid && !pushed) begin
                we.d = data[i]; we.s = strb[i]; we.l = (i == int'(len)); we.id = id;
                wq.push_back(we);
                pushed = 1'b1;
            end
            @(negedge clk);
            if (wd_valid && Wready) begin
                i++;
                pushed = 1'b0;
            end
            cyc++;
            if (stop_after >= 0 && i == stop_after) break;
            @(posedge clk); #1;
        end
        if (cyc >= 100) chk("data_phase_bound", 64'(i), 64'(int'(len) + 1));
        if (stop_after >= 0) return;

        wd_valid = 1'b0; Wready = 1'b0;
        nrdy = 0; seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            Bvalid = !b_never && (c == b_dly + 1);
            Bresp  = Bvalid ? bresp : 2'b00;
            Bid    = Bvalid ? bid : '0;
            @(negedge clk);
            if (Bready) nrdy++;
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        Bvalid = 1'b0; Bresp = 2'b00; Bid = '0;
        chk("b_ready_cycles", 64'(nrdy), 64'(b_never ? TO : b_dly + 1));
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // addr, id, len, size, burst, aw_dly, tog, gap, b_dly, never, bresp, bid, stop
        run_burst(32'h100,  4'd3, 4'd0,  3'd2, 2'b01, 0, 0, 0, 0,  0, 2'b00, 4'd3, -1);
        run_burst(32'h2000, 4'd1, 4'd7,  3'd2, 2'b01, 5, 1, 1, 2,  0, 2'b00, 4'd1, -1);
        run_burst(32'h3000, 4'd4, 4'd3,  3'd2, 2'b01, 1, 0, 0, 0,  0, 2'b10, 4'd4, -1);
        run_burst(32'h3100, 4'd2, 4'd1,  3'd2, 2'b01, 0, 0, 1, 1,  0, 2'b00, 4'd2, -1);
        run_burst(32'h4000, 4'd5, 4'd2,  3'd2, 2'b01, 0, 1, 0, 0,  0, 2'b00, 4'd6, -1);
        run_burst(32'h5000, 4'd7, 4'd1,  3'd2, 2'b01, 0, 0, 0, 0,  1, 2'b00, 4'd7, -1);
        run_burst(32'h5100, 4'd7, 4'd1,  3'd2, 2'b01, 0, 0, 0, 14, 0, 2'b00, 4'd7, -1);
        run_burst(32'h5200, 4'd8, 4'd0,  3'd2, 2'b01, 0, 0, 0, 15, 0, 2'b00, 4'd8, -1);
        run_burst(32'h6000, 4'd9, 4'd0,  3'd3, 2'b01, 0, 0, 0, 0,  0, 2'b10, 4'd9, -1);
        run_burst(32'h6100, 4'd9, 4'd2,  3'd2, 2'b10, 0, 0, 0, 0,  0, 2'b00, 4'd9, -1);
        run_burst(32'h7000, 4'hA, 4'd3,  3'd1, 2'b10, 2, 1, 1, 3,  0, 2'b00, 4'hA, -1);
        run_burst(32'h8000, 4'hB, 4'd15, 3'd0, 2'b00, 0, 0, 1, 0,  0, 2'b00, 4'hB, -1);

        // Reset lands on the negedge after the second beat of an 8-beat burst.
        saved = done_cnt;
        run_burst(32'h9000, 4'hC, 4'd7, 3'd2, 2'b01, 0, 0, 0, 0, 0, 2'b00, 4'hC, 2);
        #2;
        rst = 1'b1; wd_valid = 1'b1; Wready = 1'b1;
        #1;
        check_reset_outputs("midburst_rst");
        wq.delete();
        @(posedge clk); #1;
        wd_valid = 1'b0; Wready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("no_done_on_rst", 64'(done_cnt), 64'(saved));
        run_burst(32'hA000, 4'hD, 4'd2, 3'd2, 2'b01, 1, 1, 0, 1, 0, 2'b00, 4'hD, -1);

        repeat (3) @(posedge clk);
        chk("queues_empty", 64'(wq.size() + bq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
